// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses framed write commands arriving from uart_rx, buffers
// the payload, checks the XOR checksum, then bursts the payload into the
// register-bank write port. Nothing is written from a corrupted or
// truncated frame.
//
// Frame: HEADER, ADDR, LEN, D0..D(LEN-1), CHK  (CHK = ADDR ^ LEN ^ D0 ^ ...)
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   rx_data, rx_valid     byte stream from uart_rx (rx_valid is a level)
//   wr_valid/addr/data    register write request (held while stalled)
//   wr_ready              register bank accepts the beat
//   busy                  parser/committer not idle
//   pkt_ok                pulse after the last beat of a good packet
//   chk_err, len_err      pulses on checksum mismatch / illegal LEN
//   to_err                pulse on inter-byte timeout
//   ovr_err               pulse when a byte arrives during COMMIT (dropped)
//
// Build option: define UART_CMD_TIMEOUT_EN to enable the inter-byte timeout;
// otherwise the parser waits indefinitely and to_err stays 0.
module uart_cmd_ctrl #(
    parameter int unsigned MAX_LEN        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50_000,
    parameter logic [7:0]  HEADER         = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       busy,
    output logic       pkt_ok,
    output logic       chk_err,
    output logic       len_err,
    output logic       to_err,
    output logic       ovr_err
);

    localparam int unsigned PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH = 1 << PTR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t             state;
    logic               rx_valid_q;
    logic               accept;
    logic               parsing;
    logic               timeout;
    logic [7:0]         base;
    logic [7:0]         chk_acc;
    logic [PTR_W-1:0]   idx;
    logic [PTR_W-1:0]   last_idx;
    logic [7:0]         pbuf [DEPTH];

    // One acceptance per byte: rising edge of the held rx_valid level
    assign accept  = rx_valid & ~rx_valid_q;
    assign parsing = (state == S_ADDR) || (state == S_LEN) ||
                     (state == S_PAYLOAD) || (state == S_CHECK);

`ifdef UART_CMD_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Inter-byte timer; cleared by each accepted byte, idle outside parsing
    assign timeout = parsing && !accept &&
                     (to_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= 32'd0;
        end else if (!parsing || accept || timeout) begin
            to_cnt <= 32'd0;
        end else begin
            to_cnt <= to_cnt + 32'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Payload buffer; contents are meaningless until a frame passes CHECK
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && accept) begin
            pbuf[idx] <= rx_data;
        end
    end

    // Parser / commit FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            rx_valid_q <= 1'b1;
            base       <= 8'd0;
            chk_acc    <= 8'd0;
            idx        <= '0;
            last_idx   <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= 8'd0;
            wr_data    <= 8'd0;
            busy       <= 1'b0;
            pkt_ok     <= 1'b0;
            chk_err    <= 1'b0;
            len_err    <= 1'b0;
            to_err     <= 1'b0;
            ovr_err    <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            pkt_ok     <= 1'b0;
            chk_err    <= 1'b0;
            len_err    <= 1'b0;
            to_err     <= 1'b0;
            ovr_err    <= 1'b0;

            if (timeout) begin
                to_err <= 1'b1;
                busy   <= 1'b0;
                state  <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept && rx_data == HEADER) begin
                            busy  <= 1'b1;
                            state <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (accept) begin
                            base    <= rx_data;
                            chk_acc <= rx_data;
                            state   <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (accept) begin
                            if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                                len_err <= 1'b1;
                                busy    <= 1'b0;
                                state   <= S_IDLE;
                            end else begin
                                // Store LEN-1 so the index never needs an extra bit
                                last_idx <= PTR_W'(rx_data - 8'd1);
                                chk_acc  <= chk_acc ^ rx_data;
                                idx      <= '0;
                                state    <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (accept) begin
                            chk_acc <= chk_acc ^ rx_data;
                            if (idx == last_idx) begin
                                state <= S_CHECK;
                            end else begin
                                idx <= idx + PTR_W'(1);
                            end
                        end
                    end
                    S_CHECK: begin
                        if (accept) begin
                            if (rx_data == chk_acc) begin
                                idx      <= '0;
                                wr_valid <= 1'b1;
                                wr_addr  <= base;
                                wr_data  <= pbuf[0];
                                state    <= S_COMMIT;
                            end else begin
                                chk_err <= 1'b1;
                                busy    <= 1'b0;
                                state   <= S_IDLE;
                            end
                        end
                    end
                    S_COMMIT: begin
                        // Bytes arriving now are dropped, never parsed later
                        if (accept) begin
                            ovr_err <= 1'b1;
                        end
                        if (wr_ready) begin
                            if (idx == last_idx) begin
                                wr_valid <= 1'b0;
                                pkt_ok   <= 1'b1;
                                busy     <= 1'b0;
                                state    <= S_IDLE;
                            end else begin
                                idx     <= idx + PTR_W'(1);
                                wr_addr <= base + 8'(idx) + 8'd1;
                                wr_data <= pbuf[idx + PTR_W'(1)];
                            end
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: the stimulus process pushes expected
// register writes into a queue, the monitor pops and compares each
// transferred beat, checks stall stability and counts status pulses.
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;
    logic       pkt_ok;
    logic       chk_err;
    logic       len_err;
    logic       to_err;
    logic       ovr_err;

    uart_cmd_ctrl #(
        .MAX_LEN        (8),
        .TIMEOUT_CYCLES (100),
        .HEADER         (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .pkt_ok   (pkt_ok),
        .chk_err  (chk_err),
        .len_err  (len_err),
        .to_err   (to_err),
        .ovr_err  (ovr_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];

    // Pulse counters (written by the monitor only) and stimulus snapshots
    int n_pkt, n_chk, n_len, n_to, n_ovr;
    int s_pkt, s_chk, s_len, s_to, s_ovr;

    logic        tog_en;
    logic        ready_lvl;
    logic        held_v;
    logic [15:0] held;
    logic [15:0] exp_beat;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // wr_ready driver: fixed level or toggling every cycle
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) wr_ready = ~wr_ready;
            else        wr_ready = ready_lvl;
        end
    end

    // Monitor: beat scoreboard, stall stability, pulse counting
    initial begin
        held_v = 1'b0;
        n_pkt = 0; n_chk = 0; n_len = 0; n_to = 0; n_ovr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (pkt_ok)  n_pkt++;
                if (chk_err) n_chk++;
                if (len_err) n_len++;
                if (to_err)  n_to++;
                if (ovr_err) n_ovr++;
                if (held_v && wr_valid)
                    check("wr_stable", 32'({wr_addr, wr_data}), 32'(held));
                if (wr_valid && wr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_unexpected: got addr %0h data %0h, expected no write",
                                 wr_addr, wr_data);
                    end else begin
                        exp_beat = exp_q.pop_front();
                        check("wr_beat", 32'({wr_addr, wr_data}), 32'(exp_beat));
                    end
                end
                held_v = wr_valid && !wr_ready;
                held   = {wr_addr, wr_data};
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Frame bytes packed MSB-first; n bytes are sent
    task automatic send_frame(input logic [127:0] frame, input int n);
        for (int i = 0; i < n; i++)
            send_byte(frame[8*(n-1-i) +: 8]);
    endtask

    task automatic mark();
        s_pkt = n_pkt; s_chk = n_chk; s_len = n_len; s_to = n_to; s_ovr = n_ovr;
    endtask

    task automatic expect_counts(input int pk, input int ck, input int ln,
                                 input int to, input int ov);
        check("pkt_ok_cnt",  32'(n_pkt - s_pkt), 32'(pk));
        check("chk_err_cnt", 32'(n_chk - s_chk), 32'(ck));
        check("len_err_cnt", 32'(n_len - s_len), 32'(ln));
        check("to_err_cnt",  32'(n_to  - s_to),  32'(to));
        check("ovr_err_cnt", 32'(n_ovr - s_ovr), 32'(ov));
    endtask

    // Bounded wait for idle with the scoreboard drained
    task automatic wait_done();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", 32'(n >= 300), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tog_en    = 1'b0;
        ready_lvl = 1'b1;
        rst       = 1'b0;
        // A byte already valid at reset release must be ignored
        rx_valid  = 1'b1;
        rx_data   = 8'hA5;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_addr",  32'(wr_addr),  32'd0);
        check("rst_wr_data",  32'(wr_data),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_pkt_ok",   32'(pkt_ok),   32'd0);
        check("rst_chk_err",  32'(chk_err),  32'd0);
        check("rst_len_err",  32'(len_err),  32'd0);
        check("rst_to_err",   32'(to_err),   32'd0);
        check("rst_ovr_err",  32'(ovr_err),  32'd0);
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Good packet; CHK = 10^03^11^22^33 = 13
        mark();
        exp_q.push_back(16'h1011);
        exp_q.push_back(16'h1122);
        exp_q.push_back(16'h1233);
        send_frame(128'hA5_10_03_11_22_33, 6);
        @(posedge clk);
        #1;
        rx_data  = 8'h13;
        rx_valid = 1'b1;
        @(negedge clk);
        check("wr_valid_before_accept", 32'(wr_valid), 32'd0);
        @(negedge clk);
        check("wr_valid_after_chk", 32'(wr_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1 rx_valid = 1'b0;
        wait_done();
        expect_counts(1, 0, 0, 0, 0);

        // Bad checksum: no writes may appear
        mark();
        send_frame(128'hA5_10_03_11_22_33_20, 7);
        wait_done();
        check("bad_chk_wr_valid", 32'(wr_valid), 32'd0);
        expect_counts(0, 1, 0, 0, 0);

        // Illegal lengths 0 and 9, then a good packet
        mark();
        send_frame(128'hA5_00_00, 3);
        send_frame(128'hA5_00_09, 3);
        wait_done();
        expect_counts(0, 0, 2, 0, 0);
        mark();
        exp_q.push_back(16'h1011);
        exp_q.push_back(16'h1122);
        exp_q.push_back(16'h1233);
        send_frame(128'hA5_10_03_11_22_33_13, 7);
        wait_done();
        expect_counts(1, 0, 0, 0, 0);

        // Maximum length 8; CHK = 20^08^(01^..^08) = 20
        mark();
        for (int i = 0; i < 8; i++)
            exp_q.push_back({8'(8'h20 + i), 8'(i + 1)});
        send_frame(128'hA5_20_08_01_02_03_04_05_06_07_08_20, 12);
        wait_done();
        expect_counts(1, 0, 0, 0, 0);

        // Backpressure with address wrap; CHK = FF^02^AA^BB = EC
        mark();
        tog_en = 1'b1;
        exp_q.push_back(16'hFFAA);
        exp_q.push_back(16'h00BB);
        send_frame(128'hA5_FF_02_AA_BB_EC, 6);
        wait_done();
        tog_en = 1'b0;
        expect_counts(1, 0, 0, 0, 0);

        // Overrun during a stalled commit; CHK = 10^01^77 = 66
        ready_lvl = 1'b0;
        repeat (2) @(posedge clk);
        mark();
        exp_q.push_back(16'h1077);
        send_frame(128'hA5_10_01_77_66, 5);
        check("stalled_wr_valid", 32'(wr_valid), 32'd1);
        send_byte(8'hA5);
        ready_lvl = 1'b1;
        wait_done();
        repeat (5) @(negedge clk);
        check("ovr_no_new_pkt", 32'(busy), 32'd0);
        expect_counts(1, 0, 0, 0, 1);

        // Stalled after ADDR for more than the timeout
        mark();
        send_frame(128'hA5_10, 2);
        repeat (110) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
        check("timeout_busy", 32'(busy), 32'd0);
        expect_counts(0, 0, 0, 1, 0);
`else
        check("no_timeout_busy", 32'(busy), 32'd1);
        expect_counts(0, 0, 0, 0, 0);
`endif
        // Reset mid-packet returns to idle
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wr_valid", 32'(wr_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
